// File: rtl/reg_file_sb_pkg.sv
// ============================================================================
// Module   : reg_file_sb_pkg
// Desc     : Shared defaults and constants for the scoreboarded register file
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_sb_pkg;

  // Default register width and address width (depth = 2**ADDR_W)
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  // Address of the hardwired-zero register
  localparam int ZERO_REG   = 0;

endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
// Module   : rf_read_port
// Desc     : One combinational read port: address mux, optional write-through
//            bypass, zero-register force and busy lookup with bypass clear
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_read_port
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] busy_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              mem_en_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o
);

  // Stored value first, then load return, then ALU writeback (highest priority)
  always_comb begin
    rdata_o = regs_i[src_i];
    busy_o  = busy_i[src_i];
    if (BYPASS != 0) begin
      if (mem_en_i && (mem_addr_i == src_i)) begin
        rdata_o = mem_data_i;
        // A load returning this cycle frees the register unless a new load
        // is reserving it at the same edge
        if (!(rsv_en_i && (rsv_addr_i == src_i))) begin
          busy_o = 1'b0;
        end
      end
      if (wr_en_i && (wr_addr_i == src_i)) begin
        rdata_o = wr_data_i;
      end
    end
    if (src_i == ADDR_W'(ZERO_REG)) begin
      rdata_o = '0;
      busy_o  = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
// Module   : reg_file_sb
// Desc     : Parametrised register file with two write ports, three read
//            ports, per-register busy scoreboard and reservation error flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeValue,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] memReg,
  input  logic [DATA_W-1:0] memValue,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] reserveReg,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  input  logic [ADDR_W-1:0] srcC,
  output logic [DATA_W-1:0] ReadA,
  output logic [DATA_W-1:0] ReadB,
  output logic [DATA_W-1:0] ReadC,
  output logic              BusyA,
  output logic              BusyB,
  output logic              BusyC,
  output logic              AnyBusy,
  output logic              ResvErr
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              resv_err_q;
  logic              resv_err_d;

  // Effective enables: address 0 is never a target, and reset discards
  // same-cycle activity (also keeps bypass paths quiet during reset)
  logic wr_en, mem_en, rsv_en;
  assign wr_en  = RegWrite && !RST && (writeReg   != ADDR_W'(ZERO_REG));
  assign mem_en = MemWrite && !RST && (memReg     != ADDR_W'(ZERO_REG));
  assign rsv_en = Reserve  && !RST && (reserveReg != ADDR_W'(ZERO_REG));

  // Next-state for storage, busy scoreboard and reservation error
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (mem_en) begin
      regs_d[memReg] = memValue;
      busy_d[memReg] = 1'b0;
    end
    // ALU port overrides the load-return port on a same-register collision
    if (wr_en) begin
      regs_d[writeReg] = writeValue;
    end
    // A new reservation wins over a same-cycle busy clear
    if (rsv_en) begin
      busy_d[reserveReg] = 1'b1;
    end
    resv_err_d = rsv_en && busy_q[reserveReg]
                 && !(mem_en && (memReg == reserveReg));
  end

  // State registers with asynchronous clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      resv_err_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      resv_err_q <= resv_err_d;
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_a (
    .regs_i(regs_q), .busy_i(busy_q), .src_i(srcA),
    .wr_en_i(wr_en), .wr_addr_i(writeReg), .wr_data_i(writeValue),
    .mem_en_i(mem_en), .mem_addr_i(memReg), .mem_data_i(memValue),
    .rsv_en_i(rsv_en), .rsv_addr_i(reserveReg),
    .rdata_o(ReadA), .busy_o(BusyA)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_b (
    .regs_i(regs_q), .busy_i(busy_q), .src_i(srcB),
    .wr_en_i(wr_en), .wr_addr_i(writeReg), .wr_data_i(writeValue),
    .mem_en_i(mem_en), .mem_addr_i(memReg), .mem_data_i(memValue),
    .rsv_en_i(rsv_en), .rsv_addr_i(reserveReg),
    .rdata_o(ReadB), .busy_o(BusyB)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_c (
    .regs_i(regs_q), .busy_i(busy_q), .src_i(srcC),
    .wr_en_i(wr_en), .wr_addr_i(writeReg), .wr_data_i(writeValue),
    .mem_en_i(mem_en), .mem_addr_i(memReg), .mem_data_i(memValue),
    .rsv_en_i(rsv_en), .rsv_addr_i(reserveReg),
    .rdata_o(ReadC), .busy_o(BusyC)
  );

  // Stall request to decode
  assign AnyBusy = BusyA | BusyB | BusyC;
  assign ResvErr = resv_err_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
// Module   : tb_reg_file_sb
// Desc     : Directed self-checking bench; a bypass and a non-bypass instance
//            share stimulus, expected values flow through a scoreboard queue
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sb;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RegWrite, MemWrite, Reserve;
  logic [AW-1:0] writeReg, memReg, reserveReg, srcA, srcB, srcC;
  logic [DW-1:0] writeValue, memValue;

  logic [DW-1:0] b_ReadA, b_ReadB, b_ReadC, n_ReadA, n_ReadB, n_ReadC;
  logic          b_BusyA, b_BusyB, b_BusyC, b_AnyBusy, b_ResvErr;
  logic          n_BusyA, n_BusyB, n_BusyC, n_AnyBusy, n_ResvErr;

  always #5 CLK = ~CLK;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut_b (
    .CLK(CLK), .RST(RST),
    .RegWrite(RegWrite), .writeReg(writeReg), .writeValue(writeValue),
    .MemWrite(MemWrite), .memReg(memReg), .memValue(memValue),
    .Reserve(Reserve), .reserveReg(reserveReg),
    .srcA(srcA), .srcB(srcB), .srcC(srcC),
    .ReadA(b_ReadA), .ReadB(b_ReadB), .ReadC(b_ReadC),
    .BusyA(b_BusyA), .BusyB(b_BusyB), .BusyC(b_BusyC),
    .AnyBusy(b_AnyBusy), .ResvErr(b_ResvErr)
  );

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_n (
    .CLK(CLK), .RST(RST),
    .RegWrite(RegWrite), .writeReg(writeReg), .writeValue(writeValue),
    .MemWrite(MemWrite), .memReg(memReg), .memValue(memValue),
    .Reserve(Reserve), .reserveReg(reserveReg),
    .srcA(srcA), .srcB(srcB), .srcC(srcC),
    .ReadA(n_ReadA), .ReadB(n_ReadB), .ReadC(n_ReadC),
    .BusyA(n_BusyA), .BusyB(n_BusyB), .BusyC(n_BusyC),
    .AnyBusy(n_AnyBusy), .ResvErr(n_ResvErr)
  );

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Record what a DUT output must show at the next observation point
  task automatic push(input string tag, input logic [DW-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare the observed DUT output to it
  task automatic check(input logic [DW-1:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic clear_inputs();
    RegWrite = 1'b0; writeReg = '0; writeValue = '0;
    MemWrite = 1'b0; memReg   = '0; memValue   = '0;
    Reserve  = 1'b0; reserveReg = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    srcA = '0; srcB = '0; srcC = '0;
    #1;
    // Reset state
    push("rst_readA_b", 16'h0000); push("rst_busyA_b", 16'h0000);
    push("rst_resverr_b", 16'h0000); push("rst_resverr_n", 16'h0000);
    check(b_ReadA); check(16'(b_BusyA)); check(16'(b_ResvErr)); check(16'(n_ResvErr));
    tick(); tick();
    RST = 1'b0;

    // 1. Write reg2, then reset mid-run with a write to reg0 in flight
    RegWrite = 1'b1; writeReg = 3'd2; writeValue = 16'h00A7; srcA = 3'd2;
    tick();
    clear_inputs();
    #1;
    push("t1_reg2_b", 16'h00A7); push("t1_reg2_n", 16'h00A7);
    check(b_ReadA); check(n_ReadA);
    RST = 1'b1;
    RegWrite = 1'b1; writeReg = 3'd0; writeValue = 16'h2030;
    #1;
    push("t1_inrst_reg2_b", 16'h0000); push("t1_inrst_reg2_n", 16'h0000);
    check(b_ReadA); check(n_ReadA);
    srcA = 3'd0;
    #1;
    push("t1_inrst_reg0_b", 16'h0000);
    check(b_ReadA);
    tick();
    RST = 1'b0;
    tick();
    srcA = 3'd2;
    #1;
    push("t1_post_reg2_b", 16'h0000); push("t1_post_reg2_n", 16'h0000);
    check(b_ReadA); check(n_ReadA);
    srcA = 3'd0;
    #1;
    push("t1_post_reg0_b", 16'h0000); push("t1_post_resverr_b", 16'h0000);
    check(b_ReadA); check(16'(b_ResvErr));
    clear_inputs();

    // 2. Write with and without bypass
    RegWrite = 1'b1; writeReg = 3'd3; writeValue = 16'hABCD; srcA = 3'd3;
    #1;
    push("t2_pre_b", 16'hABCD); push("t2_pre_n", 16'h0000);
    check(b_ReadA); check(n_ReadA);
    tick();
    clear_inputs();
    #1;
    push("t2_post_b", 16'hABCD); push("t2_post_n", 16'hABCD);
    check(b_ReadA); check(n_ReadA);

    // 3. Write-port collision: ALU data wins
    RegWrite = 1'b1; writeReg = 3'd4; writeValue = 16'h1111;
    MemWrite = 1'b1; memReg   = 3'd4; memValue   = 16'h2222; srcA = 3'd4;
    #1;
    push("t3_pre_b", 16'h1111);
    check(b_ReadA);
    tick();
    clear_inputs();
    #1;
    push("t3_post_b", 16'h1111); push("t3_post_n", 16'h1111);
    check(b_ReadA); check(n_ReadA);

    // 4. Busy lifecycle on reg5
    Reserve = 1'b1; reserveReg = 3'd5;
    tick();
    clear_inputs();
    srcB = 3'd5;
    #1;
    push("t4_busyB_b", 16'h0001); push("t4_any_b", 16'h0001);
    push("t4_busyB_n", 16'h0001); push("t4_any_n", 16'h0001);
    check(16'(b_BusyB)); check(16'(b_AnyBusy)); check(16'(n_BusyB)); check(16'(n_AnyBusy));
    MemWrite = 1'b1; memReg = 3'd5; memValue = 16'h0013;
    #1;
    push("t4_ret_busyB_b", 16'h0000); push("t4_ret_readB_b", 16'h0013);
    push("t4_ret_busyB_n", 16'h0001); push("t4_ret_readB_n", 16'h0000);
    check(16'(b_BusyB)); check(b_ReadB); check(16'(n_BusyB)); check(n_ReadB);
    tick();
    clear_inputs();
    #1;
    push("t4_after_busyB_b", 16'h0000); push("t4_after_any_b", 16'h0000);
    push("t4_after_busyB_n", 16'h0000); push("t4_after_readB_n", 16'h0013);
    check(16'(b_BusyB)); check(16'(b_AnyBusy)); check(16'(n_BusyB)); check(n_ReadB);

    // 5. Reservation corner cases on reg6 and reg0
    srcC = 3'd6;
    Reserve = 1'b1; reserveReg = 3'd6;
    tick();
    #1;
    push("t5_first_resverr_b", 16'h0000);
    check(16'(b_ResvErr));
    tick();
    Reserve = 1'b0;
    #1;
    push("t5_double_resverr_b", 16'h0001); push("t5_double_resverr_n", 16'h0001);
    push("t5_double_busyC_b", 16'h0001);
    check(16'(b_ResvErr)); check(16'(n_ResvErr)); check(16'(b_BusyC));
    tick();
    #1;
    push("t5_pulse_end_b", 16'h0000); push("t5_still_busy_b", 16'h0001);
    check(16'(b_ResvErr)); check(16'(b_BusyC));
    Reserve = 1'b1; reserveReg = 3'd6;
    MemWrite = 1'b1; memReg = 3'd6; memValue = 16'h0066;
    #1;
    push("t5_rsvmem_pre_busyC_b", 16'h0001); push("t5_rsvmem_pre_readC_b", 16'h0066);
    check(16'(b_BusyC)); check(b_ReadC);
    tick();
    clear_inputs();
    #1;
    push("t5_rsvmem_busyC_n", 16'h0001); push("t5_rsvmem_readC_n", 16'h0066);
    push("t5_rsvmem_resverr_n", 16'h0000);
    check(16'(n_BusyC)); check(n_ReadC); check(16'(n_ResvErr));
    srcC = 3'd0;
    Reserve = 1'b1; reserveReg = 3'd0;
    tick();
    tick();
    clear_inputs();
    #1;
    push("t5_r0_resverr_n", 16'h0000); push("t5_r0_busyC_n", 16'h0000);
    push("t5_r0_readC_n", 16'h0000);
    check(16'(n_ResvErr)); check(16'(n_BusyC)); check(n_ReadC);

    // 6. Disabled write leaves reg2 alone
    RegWrite = 1'b0; writeReg = 3'd2; writeValue = 16'hABCD; srcA = 3'd2;
    #1;
    push("t6_pre_b", 16'h0000);
    check(b_ReadA);
    tick();
    #1;
    push("t6_post_b", 16'h0000); push("t6_post_n", 16'h0000);
    check(b_ReadA); check(n_ReadA);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
